infer_result_scorer: RTL and testbench
======================================

// Module: infer_result_scorer
// PURPOSE
// - Sits downstream of the SNN core, upstream of the result FIFO feeding host pipe-out.
// - Consumes the per-class neuron-voltage burst (one class per cycle on output_valid).
// - Computes the argmax class, scores it against the queued MNIST label and keeps accuracy counters.
// - Presents one result word per frame through a valid/ready handshake.
// PARAMETERS
// NUM_CLASSES  10  classes per output_valid burst (index field 4 bits, max 16)
// V_W          10  signed voltage width, neuron_voltages[V_W-1:0]
// LQ_DEPTH     4   label queue depth (power of 2)
// PORTS
// clk             in   1   core clock
// resetn          in   1   asynchronous active-low reset
// label_in        in   4   label from label FIFO
// label_push      in   1   label_in valid this cycle (same cycle as label_request)
// neuron_voltages in   14  [13:10] class index, [9:0] signed voltage
// output_valid    in   1   voltage beat valid
// result_data     out  8   {correct, 3'b0, guess[3:0]}
// result_valid    out  1   result word available
// result_ready    in   1   downstream accepts result word
// correct_count   out  32  frames with guess == label
// frame_count     out  32  frames completed (including dropped)
// err_flags       out  4   sticky {overrun, no_label, short_frame, seq_err}
// clr_stats       in   1   sync clear of counters and err_flags
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; label queue empty.
// - FSM states: IDLE, ACCUM, EMIT.
//   - IDLE->ACCUM on output_valid; beat 0 processed in that same cycle.
//   - ACCUM stays while output_valid and cnt < NUM_CLASSES-1.
// - Running max:
//   - Init max = most negative (10'b10_0000_0000), guess = 0.
//   - Update only on strictly greater ($signed), so ties keep the lowest index.
// - Beat index check: neuron_voltages[13:10] != cnt sets seq_err sticky; the beat is still used in argmax.
// - Frame complete: beat cnt == NUM_CLASSES-1 consumed.
//   - Pop label: correct = (label == guess) computed on the final-beat value, including that beat's update.
//   - frame_count += 1; correct_count += correct.
//   - Go to EMIT with result_valid = 1 on the next cycle. Latency: last beat -> result_valid = 1 cycle.
// - Label queue empty at frame complete: correct = 0, no_label set, no pop.
// - output_valid drops in ACCUM before the last beat:
//   - Set short_frame; discard the frame (no counters, no pop); go to IDLE.
// - EMIT:
//   - result_data is held stable while result_valid && !result_ready.
//   - Handshake when result_valid && result_ready; result_valid falls next cycle; go to IDLE, or ACCUM if output_valid that cycle.
//   - output_valid in EMIT with no handshake: new frame accumulates.
//   - If that frame completes while the old word is still pending, the new word is dropped: overrun set, counters still updated.
// - Label queue:
//   - Push when label_push; pop at frame complete.
//   - Push and pop in the same cycle: occupancy unchanged, allowed when full.
//   - Push when full without pop: ignored, no_label set (lost label).
//   - Pointers wrap modulo LQ_DEPTH.
// - Counters wrap at 2^32 without saturation.
// - clr_stats clears counters and err_flags only. Same cycle as a frame complete: clear wins, increment lost.
// - resetn low mid-frame or mid-EMIT: immediate async clear; partial frame and pending word discarded.
// TESTING
// - Voltages idx0..9 = {-5,3,7,7,-512,0,1,2,6,-1}, label 2 -> result_data 8'h82; correct_count 1; frame_count 1.
// - All ten voltages = -512, label 0 -> guess 0, result_data 8'h80 (tie/min handling).
// - result_ready low 20 cycles after result -> result_data stable; second full frame completes -> overrun set, first word delivered.
// - output_valid drops after beat 6 -> short_frame set, frame_count 0, label still queued for next frame.
// - Beat 3 carries index 5 -> seq_err set, argmax still correct; no labels pushed -> no_label set, correct 0.
// - resetn pulsed low at beat 4 -> outputs 0 asynchronously; next clean frame scores normally.

Source files
------------

// File: rtl/infer_result_scorer_if.sv
// -----------------------------------------------------------------------------
// infer_result_scorer_if
// Bundles the scorer's streaming signals.
//   label_in / label_push         : label from the label FIFO (one per frame)
//   neuron_voltages / output_valid: per-class voltage beat {idx[3:0], volt[V_W-1:0]}
//   result_data / result_valid /
//   result_ready                  : result word handshake toward the result FIFO
// Modports:
//   master : the side that produces beats/labels and consumes result words
//   slave  : the scorer
// -----------------------------------------------------------------------------
interface infer_result_scorer_if #(
  parameter int V_W = 10
);
  logic [3:0]     label_in;
  logic           label_push;
  logic [V_W+3:0] neuron_voltages;
  logic           output_valid;
  logic [7:0]     result_data;
  logic           result_valid;
  logic           result_ready;

  modport master (
    output label_in,
    output label_push,
    output neuron_voltages,
    output output_valid,
    output result_ready,
    input  result_data,
    input  result_valid
  );

  modport slave (
    input  label_in,
    input  label_push,
    input  neuron_voltages,
    input  output_valid,
    input  result_ready,
    output result_data,
    output result_valid
  );
endinterface

// File: rtl/infer_result_scorer.sv
// -----------------------------------------------------------------------------
// infer_result_scorer
// Consumes the per-class voltage burst from the SNN core, finds the argmax
// class, scores it against the queued label and presents one result word per
// frame over a valid/ready handshake. Keeps frame/correct counters and sticky
// error flags.
// Ports:
//   clk           : core clock
//   resetn        : asynchronous active-low reset
//   bus           : infer_result_scorer_if.slave (labels, voltage beats, result word)
//   clr_stats     : synchronous clear of counters and err_flags
//   correct_count : frames whose guess matched the label
//   frame_count   : frames completed (dropped result words included)
//   err_flags     : sticky {overrun, no_label, short_frame, seq_err}
// -----------------------------------------------------------------------------
module infer_result_scorer #(
  parameter int NUM_CLASSES = 10,
  parameter int V_W         = 10,
  parameter int LQ_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  infer_result_scorer_if.slave  bus,
  input  logic                  clr_stats,
  output logic [31:0]           correct_count,
  output logic [31:0]           frame_count,
  output logic [3:0]            err_flags
);

  localparam int          LQ_AW    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_CLASSES - 1);
  localparam logic [LQ_AW:0] LQ_FULL = (LQ_AW + 1)'(LQ_DEPTH);
  // Most negative representable voltage: running max starts here.
  localparam logic [V_W-1:0] V_MIN = {1'b1, {(V_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t             state_r;
  logic               acc_busy_r;   // a frame is in progress while a word waits in EMIT
  logic [3:0]         cnt_r;
  logic [V_W-1:0]     max_r;
  logic [3:0]         guess_r;
  logic [7:0]         result_data_r;
  logic               result_valid_r;

  logic [3:0]         lq_mem_r [LQ_DEPTH];
  logic [LQ_AW-1:0]   lq_wr_r;
  logic [LQ_AW-1:0]   lq_rd_r;
  logic [LQ_AW:0]     lq_cnt_r;

  logic [31:0]        correct_count_r;
  logic [31:0]        frame_count_r;
  logic [3:0]         err_r;

  logic [V_W-1:0]     voltage_s;
  logic [3:0]         idx_s;
  logic               acc_busy_s;
  logic [3:0]         cur_cnt_s;
  logic [V_W-1:0]     base_max_s;
  logic [3:0]         base_guess_s;
  logic [V_W-1:0]     new_max_s;
  logic [3:0]         new_guess_s;
  logic               seq_bad_s;
  logic               frame_done_s;
  logic               cont_s;
  logic               short_s;
  logic               lq_empty_s;
  logic               lq_full_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               lost_s;
  logic [3:0]         head_label_s;
  logic               correct_s;
  logic               hs_s;
  logic               load_s;
  logic               overrun_s;
  logic               no_label_s;

  // Beat decode, running-argmax update and frame/queue event decode.
  always_comb begin
    voltage_s    = bus.neuron_voltages[V_W-1:0];
    idx_s        = bus.neuron_voltages[V_W+3:V_W];

    case (state_r)
      ST_ACCUM: acc_busy_s = 1'b1;
      ST_EMIT:  acc_busy_s = acc_busy_r;
      ST_IDLE:  acc_busy_s = 1'b0;
      default:  acc_busy_s = 1'b0;
    endcase

    // A beat with no frame in progress is beat 0 and starts from the reset max.
    if (acc_busy_s) begin
      cur_cnt_s    = cnt_r;
      base_max_s   = max_r;
      base_guess_s = guess_r;
    end else begin
      cur_cnt_s    = 4'd0;
      base_max_s   = V_MIN;
      base_guess_s = 4'd0;
    end

    // Strictly greater keeps the lowest index on ties.
    if ($signed(voltage_s) > $signed(base_max_s)) begin
      new_max_s   = voltage_s;
      new_guess_s = cur_cnt_s;
    end else begin
      new_max_s   = base_max_s;
      new_guess_s = base_guess_s;
    end

    seq_bad_s    = bus.output_valid && (idx_s != cur_cnt_s);
    frame_done_s = bus.output_valid && (cur_cnt_s == LAST_IDX);
    cont_s       = bus.output_valid && !frame_done_s;
    short_s      = acc_busy_s && !bus.output_valid;

    lq_empty_s   = (lq_cnt_r == '0);
    lq_full_s    = (lq_cnt_r == LQ_FULL);
    pop_s        = frame_done_s && !lq_empty_s;
    // A push into a full queue is still accepted when a pop frees a slot the same cycle.
    push_ok_s    = bus.label_push && (!lq_full_s || pop_s);
    lost_s       = bus.label_push && lq_full_s && !pop_s;
    head_label_s = lq_mem_r[lq_rd_r];
    correct_s    = pop_s && (head_label_s == new_guess_s);

    hs_s         = result_valid_r && bus.result_ready;
    // The new word replaces the old one only if the old one leaves this cycle.
    load_s       = frame_done_s && (!result_valid_r || hs_s);
    overrun_s    = frame_done_s && result_valid_r && !hs_s;
    no_label_s   = (frame_done_s && lq_empty_s) || lost_s;
  end

  // Scorer FSM with argmax accumulator and registered result word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      acc_busy_r     <= 1'b0;
      cnt_r          <= 4'd0;
      max_r          <= V_MIN;
      guess_r        <= 4'd0;
      result_data_r  <= 8'd0;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          if (load_s) begin
            state_r <= ST_EMIT;
          end else if (cont_s) begin
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (load_s || (result_valid_r && !hs_s)) begin
            state_r <= ST_EMIT;
          end else if (cont_s) begin
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      acc_busy_r <= cont_s;
      if (cont_s) begin
        cnt_r   <= cur_cnt_s + 4'd1;
        max_r   <= new_max_s;
        guess_r <= new_guess_s;
      end else begin
        cnt_r   <= 4'd0;
        max_r   <= V_MIN;
        guess_r <= 4'd0;
      end

      if (load_s) begin
        result_data_r  <= {correct_s, 3'b000, new_guess_s};
        result_valid_r <= 1'b1;
      end else if (hs_s) begin
        result_valid_r <= 1'b0;
      end else begin
        result_valid_r <= result_valid_r;
      end
    end
  end

  // Label queue: circular buffer, pointers wrap modulo LQ_DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_mem_r[i] <= 4'd0;
      end
      lq_wr_r  <= '0;
      lq_rd_r  <= '0;
      lq_cnt_r <= '0;
    end else begin
      if (push_ok_s) begin
        lq_mem_r[lq_wr_r] <= bus.label_in;
        lq_wr_r           <= lq_wr_r + 1'b1;
      end
      if (pop_s) begin
        lq_rd_r <= lq_rd_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   lq_cnt_r <= lq_cnt_r + 1'b1;
        2'b01:   lq_cnt_r <= lq_cnt_r - 1'b1;
        default: lq_cnt_r <= lq_cnt_r;
      endcase
    end
  end

  // Accuracy counters and sticky error flags; clear beats a same-cycle update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      correct_count_r <= 32'd0;
      frame_count_r   <= 32'd0;
      err_r           <= 4'd0;
    end else if (clr_stats) begin
      correct_count_r <= 32'd0;
      frame_count_r   <= 32'd0;
      err_r           <= 4'd0;
    end else begin
      if (frame_done_s) begin
        frame_count_r   <= frame_count_r + 32'd1;
        correct_count_r <= correct_count_r + {31'd0, correct_s};
      end
      err_r <= err_r | {overrun_s, no_label_s, short_s, seq_bad_s};
    end
  end

  assign bus.result_data  = result_data_r;
  assign bus.result_valid = result_valid_r;
  assign correct_count    = correct_count_r;
  assign frame_count      = frame_count_r;
  assign err_flags        = err_r;

endmodule

// File: tb/tb_infer_result_scorer.sv
// -----------------------------------------------------------------------------
// tb_infer_result_scorer
// Table-driven frames with a scoreboard of expected result words, followed by
// hand-written sequences for backpressure/overrun, short frame, index error,
// missing label, async reset mid-frame and label queue overflow.
// -----------------------------------------------------------------------------
module tb_infer_result_scorer;

  typedef logic [9:0][9:0] vec_t;
  typedef struct packed {
    vec_t       v;
    logic [3:0] label;
    logic [7:0] exp_data;
  } vec_rec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clr_stats = 1'b0;
  logic [31:0] correct_count;
  logic [31:0] frame_count;
  logic [3:0]  err_flags;

  infer_result_scorer_if bus ();

  infer_result_scorer dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .clr_stats     (clr_stats),
    .correct_count (correct_count),
    .frame_count   (frame_count),
    .err_flags     (err_flags)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each accepted result word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (resetn && bus.result_valid && bus.result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.result_data);
      end else begin
        check("result_data", 32'(bus.result_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_label(input logic [3:0] l);
    bus.label_in   = l;
    bus.label_push = 1'b1;
    tick();
    bus.label_push = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic drive_frame(input vec_t v, input int nbeats, input int bad_beat, input logic [3:0] bad_idx);
    for (int i = 0; i < nbeats; i++) begin
      bus.output_valid    = 1'b1;
      bus.neuron_voltages = {((i == bad_beat) ? bad_idx : 4'(i)), v[i]};
      tick();
    end
    bus.output_valid    = 1'b0;
    bus.neuron_voltages = 14'd0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  vec_rec_t tbl [6];
  int       init_v [6][10];
  int       init_l [6];
  int       init_e [6];
  vec_t     v5;
  logic     stable;
  int       exp_correct;

  initial begin
    bus.label_in        = 4'd0;
    bus.label_push      = 1'b0;
    bus.neuron_voltages = 14'd0;
    bus.output_valid    = 1'b0;
    bus.result_ready    = 1'b0;

    init_v = '{
      '{-5, 3, 7, 7, -512, 0, 1, 2, 6, -1},
      '{-512, -512, -512, -512, -512, -512, -512, -512, -512, -512},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100},
      '{511, 511, 511, 511, 511, 511, 511, 511, 511, 511},
      '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10},
      '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}
    };
    init_l = '{2, 0, 9, 3, 5, 7};
    init_e = '{'h82, 'h80, 'h89, 'h00, 'h00, 'h09};
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 10; i++) begin
        tbl[k].v[i] = 10'(init_v[k][i]);
      end
      tbl[k].label    = 4'(init_l[k]);
      tbl[k].exp_data = 8'(init_e[k]);
    end
    v5    = '0;
    v5[5] = 10'd300;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result_data", 32'(bus.result_data), 32'd0);
    check("rst_correct_count", correct_count, 32'd0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_err_flags", 32'(err_flags), 32'd0);
    resetn = 1'b1;
    tick();

    // Table-driven frames with ready held high
    bus.result_ready = 1'b1;
    exp_correct = 0;
    for (int k = 0; k < 6; k++) begin
      push_label(tbl[k].label);
      exp_q.push_back(tbl[k].exp_data);
      drive_frame(tbl[k].v, 10, -1, 4'd0);
      check("latency_valid", 32'(bus.result_valid), 32'd1);
      wait_drain(10);
      exp_correct += int'(tbl[k].exp_data[7]);
      check("tbl_frame_count", frame_count, 32'(k + 1));
      check("tbl_correct_count", correct_count, 32'(exp_correct));
    end
    check("tbl_err_flags", 32'(err_flags), 32'd0);

    // Backpressure: word held, second frame overruns
    pulse_clr();
    check("clr_frame_count", frame_count, 32'd0);
    bus.result_ready = 1'b0;
    push_label(4'd2);
    push_label(4'd0);
    exp_q.push_back(8'h82);
    drive_frame(tbl[0].v, 10, -1, 4'd0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.result_data !== 8'h82 || bus.result_valid !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    tick();
    drive_frame(tbl[1].v, 10, -1, 4'd0);
    check("ovr_err_flags", 32'(err_flags), 32'h8);
    check("ovr_frame_count", frame_count, 32'd2);
    check("ovr_correct_count", correct_count, 32'd2);
    check("ovr_held_data", 32'(bus.result_data), 32'h82);
    bus.result_ready = 1'b1;
    wait_drain(10);
    tick();
    check("ovr_valid_low", 32'(bus.result_valid), 32'd0);

    // Short frame: dropped, label kept for the next frame
    pulse_clr();
    push_label(4'd5);
    drive_frame(tbl[0].v, 7, -1, 4'd0);
    tick();
    check("short_err_flags", 32'(err_flags), 32'h2);
    check("short_frame_count", frame_count, 32'd0);
    exp_q.push_back(8'h85);
    drive_frame(v5, 10, -1, 4'd0);
    wait_drain(10);
    check("short_next_correct", correct_count, 32'd1);
    check("short_next_frames", frame_count, 32'd1);

    // Index error on beat 3 with no label queued
    pulse_clr();
    exp_q.push_back(8'h02);
    drive_frame(tbl[0].v, 10, 3, 4'd5);
    wait_drain(10);
    check("seq_err_flags", 32'(err_flags), 32'h5);
    check("seq_correct_count", correct_count, 32'd0);
    check("seq_frame_count", frame_count, 32'd1);

    // Asynchronous reset at beat 4
    push_label(4'd2);
    for (int i = 0; i < 4; i++) begin
      bus.output_valid    = 1'b1;
      bus.neuron_voltages = {4'(i), tbl[0].v[i]};
      tick();
    end
    bus.neuron_voltages = {4'd4, tbl[0].v[4]};
    #2;
    resetn = 1'b0;
    #1;
    check("arst_frame_count", frame_count, 32'd0);
    check("arst_err_flags", 32'(err_flags), 32'd0);
    check("arst_result_valid", 32'(bus.result_valid), 32'd0);
    tick();
    bus.output_valid    = 1'b0;
    bus.neuron_voltages = 14'd0;
    resetn              = 1'b1;
    tick();
    push_label(4'd2);
    exp_q.push_back(8'h82);
    drive_frame(tbl[0].v, 10, -1, 4'd0);
    wait_drain(10);
    check("arst_next_correct", correct_count, 32'd1);
    check("arst_next_frames", frame_count, 32'd1);
    check("arst_next_err", 32'(err_flags), 32'd0);

    // Label queue overflow
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      push_label(4'(i));
    end
    check("lq_full_no_err", 32'(err_flags), 32'd0);
    push_label(4'd9);
    check("lq_lost_label", 32'(err_flags), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
